disp_hex_mux: RTL

- Time-multiplexed 4-digit 7-segment driver sitting directly downstream of the score counter.
- Takes four 4-bit hex/BCD digits; score digits land on hex2/hex3, other digits come from game control.
- Scans one digit at a time, decodes it to active-low segments and drives active-low anodes.
- Adds per-digit blanking, per-digit blinking, a dead cycle between digits against ghosting, and tear-free snapshotting of the inputs once per full scan.

---
 rtl/disp_hex_mux.sv | 129 ++++++++++++
 1 files changed

// File: rtl/disp_hex_mux.sv
// Four-digit multiplexed 7-segment driver with per-digit blank/blink, dead cycle and scan-boundary snapshot.
// Latency: outputs registered, one clk behind the slot state; no backpressure (level inputs, sampled at end of scan).
module disp_hex_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_SCANS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hex0,
    input  logic [3:0] hex1,
    input  logic [3:0] hex2,
    input  logic [3:0] hex3,
    input  logic [3:0] dp_in,
    input  logic [3:0] blank,
    input  logic [3:0] blink_en,
    output logic [3:0] an,
    output logic [6:0] sseg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(BLINK_SCANS - 1);

    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_idx;
    logic [SW-1:0]   r_scan;
    logic            r_phase;
    logic [3:0][3:0] r_hex_sh;
    logic [3:0]      r_dp_sh;
    logic [3:0]      r_blank_sh;
    logic [3:0]      r_blink_sh;
    logic [3:0]      r_an;
    logic [6:0]      r_sseg;
    logic            r_dp;

    logic            w_wrap;
    logic            w_eos;
    logic            w_dark;
    logic [3:0]      w_hex_cur;
    logic [6:0]      w_seg;
    logic [3:0]      w_an_nxt;
    logic [6:0]      w_sseg_nxt;
    logic            w_dp_nxt;

    assign w_wrap    = (r_cnt == CNT_LAST);
    assign w_eos     = w_wrap && (r_idx == 2'd3);
    assign w_hex_cur = r_hex_sh[r_idx];
    // blank wins over blink; the anode stays driven either way to keep brightness even
    assign w_dark    = r_blank_sh[r_idx] || (r_blink_sh[r_idx] && !r_phase);

    always_comb begin
        w_seg = 7'b1111111;
        case (w_hex_cur)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            4'hF: w_seg = 7'b0001110;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_comb begin
        w_an_nxt   = 4'b1111;
        w_sseg_nxt = 7'b1111111;
        w_dp_nxt   = 1'b1;
        if (r_cnt != '0) begin
            w_an_nxt = ~(4'b0001 << r_idx);
            if (!w_dark) begin
                w_sseg_nxt = w_seg;
                w_dp_nxt   = ~r_dp_sh[r_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_scan     <= '0;
            r_phase    <= 1'b1;
            r_hex_sh   <= '0;
            r_dp_sh    <= '0;
            r_blank_sh <= '0;
            r_blink_sh <= '0;
            r_an       <= 4'b1111;
            r_sseg     <= 7'b1111111;
            r_dp       <= 1'b1;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_an   <= w_an_nxt;
            r_sseg <= w_sseg_nxt;
            r_dp   <= w_dp_nxt;
            if (w_wrap) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_eos) begin
                r_hex_sh   <= {hex3, hex2, hex1, hex0};
                r_dp_sh    <= dp_in;
                r_blank_sh <= blank;
                r_blink_sh <= blink_en;
                if (r_scan == SCAN_LAST) begin
                    r_scan  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_scan <= r_scan + 1'b1;
                end
            end
        end
    end

    assign an   = r_an;
    assign sseg = r_sseg;
    assign dp   = r_dp;

endmodule
